// File: rtl/dtfag_pkg.sv
// rtl/dtfag_pkg.sv - shared parameters, types and twiddle mask helper for the DTFAG index path
package dtfag_pkg;

  localparam int N_POINT    = 65536;
  localparam int RADIX_LOG2 = 4;
  localparam int STAGES     = 4;
  localparam int J_W        = 12;
  localparam int T_W        = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [J_W-1:0] i;
    logic [T_W-1:0] t;
    logic [J_W-1:0] j;
  } dtfag_idx_t;

  // i keeps only the low RADIX_LOG2*(STAGES-1-t) bits of j
  function automatic logic [J_W-1:0] twiddle_mask(input logic [T_W-1:0] t);
    return J_W'((1 << (RADIX_LOG2 * (STAGES - 1 - int'(t)))) - 1);
  endfunction

endpackage

// File: rtl/dtfag_index_seq_cnt.sv
// rtl/dtfag_index_seq_cnt.sv - stage/butterfly counter pair with wrap and terminal-count flags
module dtfag_stage_cnt
  import dtfag_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           en,
  output logic [T_W-1:0] t,
  output logic [J_W-1:0] j,
  output logic [T_W-1:0] t_nxt,
  output logic [J_W-1:0] j_nxt,
  output logic           j_wrap,
  output logic           terminal
);

  always_comb begin
    j_wrap   = &j;
    terminal = j_wrap && (t == T_W'(STAGES - 1));
    t_nxt    = t;
    j_nxt    = j;
    if (clr) begin
      t_nxt = '0;
      j_nxt = '0;
    end else if (en) begin
      j_nxt = j + J_W'(1);
      if (j_wrap) t_nxt = t + T_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t <= '0;
      j <= '0;
    end else begin
      t <= t_nxt;
      j <= j_nxt;
    end
  end

endmodule

// File: rtl/dtfag_index_seq.sv
// rtl/dtfag_index_seq.sv - radix-16 65536-point FFT index sequencer feeding the twiddle address generator
module dtfag_index_seq
  import dtfag_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  output logic [J_W-1:0] DTFAG_i,
  output logic [T_W-1:0] DTFAG_t,
  output logic [J_W-1:0] DTFAG_j,
  output logic           idx_valid,
  input  logic           idx_ready,
  output logic           busy,
  output logic           stage_done,
  output logic           done
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_LAST = LAST;

  logic [1:0]     state, state_nxt;
  logic           cnt_clr, cnt_en, j_wrap, terminal, accept;
  logic [T_W-1:0] t_nxt;
  logic [J_W-1:0] j_nxt, i_nxt;
  logic           valid_nxt, busy_nxt, sd_nxt, done_nxt;

  // counter registers double as the DTFAG_t / DTFAG_j output registers
  dtfag_stage_cnt u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .t        (DTFAG_t),
    .j        (DTFAG_j),
    .t_nxt    (t_nxt),
    .j_nxt    (j_nxt),
    .j_wrap   (j_wrap),
    .terminal (terminal)
  );

  assign accept = idx_valid && idx_ready;

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    valid_nxt = idx_valid;
    sd_nxt    = 1'b0;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_nxt = ST_RUN;
            cnt_clr   = 1'b1;
            valid_nxt = 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            cnt_en = 1'b1;
            sd_nxt = j_wrap;
            if (terminal) begin
              state_nxt = ST_LAST;
              valid_nxt = 1'b0;
              done_nxt  = 1'b1;
            end
          end
        end
        ST_LAST: begin
          state_nxt = ST_IDLE;
          valid_nxt = 1'b0;
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_clr   = 1'b1;
          valid_nxt = 1'b0;
        end
      endcase
    end
    busy_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_LAST);
    i_nxt    = j_nxt & twiddle_mask(t_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      DTFAG_i    <= '0;
      idx_valid  <= 1'b0;
      busy       <= 1'b0;
      stage_done <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      DTFAG_i    <= i_nxt;
      idx_valid  <= valid_nxt;
      busy       <= busy_nxt;
      stage_done <= sd_nxt;
      done       <= done_nxt;
    end
  end

endmodule
